// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht
//
// IF-stage dynamic branch predictor. A pattern history table (PHT) of
// saturating counters is indexed by the fetch PC. In gshare mode the PC is
// XORed with a speculative global history register (GHR). The next fetch PC
// is produced combinationally in the same cycle. EX-stage resolution trains
// the PHT, and a mispredict report repairs the GHR.
//
// Parameters
//   ADDR_SIZE : PC / address width (at least 21 so that the J-immediate fits)
//   ENTRIES   : PHT entry count, power of two, >= 4
//   CNT_W     : counter width 1..4; the counter MSB gives the taken prediction
//   INIT_CNT  : reset value of every counter
//   GHR_W     : global history bits; 0 selects bimodal, else 1..IDX_W
//
// Ports
//   clk            : clock, rising edge
//   rstn           : asynchronous active-low reset
//   instr          : fetched instruction
//   pc, pcplus4    : fetch PC and fetch PC + 4
//   fetch_en       : IF advances this cycle (gates only the GHR shift)
//   predicted_pc   : next fetch PC
//   pred_taken     : conditional-branch prediction for instr
//   pred_idx       : PHT index used, carried down to EX
//   pred_ghr       : GHR snapshot used, carried down to EX (0 in bimodal mode)
//   upd_valid      : a conditional branch resolved in EX this cycle
//   upd_idx        : pred_idx carried with that branch
//   upd_taken      : actual outcome
//   upd_mispredict : outcome differed from prediction (qualified by upd_valid)
//   upd_ghr        : pred_ghr carried with that branch
// ---------------------------------------------------------------------------
module branch_predictor_bht #(
    parameter int ADDR_SIZE = 32,
    parameter int ENTRIES   = 64,
    parameter int CNT_W     = 2,
    parameter int INIT_CNT  = 1,
    parameter int GHR_W     = 0,
    localparam int IDX_W    = $clog2(ENTRIES),
    localparam int GHW      = (GHR_W > 0) ? GHR_W : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [31:0]          instr,
    input  logic [ADDR_SIZE-1:0] pc,
    input  logic [ADDR_SIZE-1:0] pcplus4,
    input  logic                 fetch_en,
    output logic [ADDR_SIZE-1:0] predicted_pc,
    output logic                 pred_taken,
    output logic [IDX_W-1:0]     pred_idx,
    output logic [GHW-1:0]       pred_ghr,
    input  logic                 upd_valid,
    input  logic [IDX_W-1:0]     upd_idx,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    input  logic [GHW-1:0]       upd_ghr
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    logic                 w_is_br;
    logic                 w_is_jal;
    logic [ADDR_SIZE-1:0] w_b_imm;
    logic [ADDR_SIZE-1:0] w_j_imm;

    assign w_is_br  = (instr[6:0] == 7'b1100011);
    assign w_is_jal = (instr[6:0] == 7'b1101111);

    // Sized casts of signed values sign-extend to the full address width.
    assign w_b_imm = ADDR_SIZE'($signed({instr[31], instr[7], instr[30:25],
                                          instr[11:8], 1'b0}));
    assign w_j_imm = ADDR_SIZE'($signed({instr[31], instr[19:12], instr[20],
                                          instr[30:21], 1'b0}));

    // -----------------------------------------------------------------------
    // Index formation and global history
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] w_pc_idx;
    logic [IDX_W-1:0] w_idx;

    assign w_pc_idx = pc[IDX_W+1:2];

    generate
        if (GHR_W > 0) begin : g_gshare
            logic [GHR_W-1:0] r_ghr;
            logic [GHR_W-1:0] w_ghr_shift;
            logic [GHR_W-1:0] w_ghr_repair;

            if (GHR_W == 1) begin : g_w1
                assign w_ghr_shift  = pred_taken;
                assign w_ghr_repair = upd_taken;
            end else begin : g_wn
                assign w_ghr_shift  = {r_ghr[GHR_W-2:0], pred_taken};
                // Rebuild history as it should have been after the resolved
                // branch: its snapshot plus the real outcome.
                assign w_ghr_repair = {upd_ghr[GHR_W-2:0], upd_taken};
            end

            // Repair beats the speculative shift: the fetched instruction is
            // on the wrong path and is about to be flushed anyway.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_ghr <= '0;
                end else if (upd_valid && upd_mispredict) begin
                    r_ghr <= w_ghr_repair;
                end else if (fetch_en && w_is_br) begin
                    r_ghr <= w_ghr_shift;
                end
            end

            assign w_idx    = w_pc_idx ^ IDX_W'(r_ghr);
            assign pred_ghr = r_ghr;
        end else begin : g_bimodal
            logic w_unused;
            assign w_unused = ^{upd_ghr, upd_mispredict, fetch_en};
            assign w_idx    = w_pc_idx;
            assign pred_ghr = '0;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Pattern history table
    // Register array rather than RAM: every entry must clear asynchronously
    // and the prediction read is combinational.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] r_pht [ENTRIES];
    logic [CNT_W-1:0] w_upd_cnt;
    logic [CNT_W-1:0] w_upd_next;
    logic [CNT_W-1:0] w_rd_cnt;

    assign w_upd_cnt = r_pht[upd_idx];

    always_comb begin
        w_upd_next = w_upd_cnt;
        if (upd_taken) begin
            if (w_upd_cnt != CNT_MAX) begin
                w_upd_next = w_upd_cnt + 1'b1;
            end
        end else begin
            if (w_upd_cnt != CNT_ZERO) begin
                w_upd_next = w_upd_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_pht[i] <= CNT_INIT;
            end
        end else if (upd_valid) begin
            r_pht[upd_idx] <= w_upd_next;
        end
    end

    // Reads the registered value only: a same-cycle update to the same entry
    // becomes visible on the following cycle.
    assign w_rd_cnt = r_pht[w_idx];

    // -----------------------------------------------------------------------
    // Prediction outputs
    // -----------------------------------------------------------------------
    assign pred_taken = w_is_br & w_rd_cnt[CNT_W-1];
    assign pred_idx   = w_idx;

    always_comb begin
        predicted_pc = pcplus4;
        if (w_is_jal) begin
            predicted_pc = pc + w_j_imm;
        end else if (pred_taken) begin
            predicted_pc = pc + w_b_imm;
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

    localparam int AW   = 32;
    localparam int ENT  = 64;
    localparam int CW   = 2;
    localparam int INIT = 1;
    localparam int GW   = 4;
    localparam int IW   = 6;
    localparam int CMAX = (1 << CW) - 1;
    localparam int THR  = 1 << (CW - 1);

    localparam logic [31:0] BEQ = 32'h0000_0863;  // beq x0,x0,+16
    localparam logic [31:0] JAL = 32'h0200_006F;  // jal x0,+32
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [31:0]   instr = '0;
    logic [AW-1:0] pc = '0;
    logic [AW-1:0] pcplus4 = '0;
    logic          fetch_en = 1'b0;
    logic          upd_valid = 1'b0;
    logic [IW-1:0] upd_idx = '0;
    logic          upd_taken = 1'b0;
    logic          upd_mispredict = 1'b0;
    logic [GW-1:0] upd_ghr = '0;

    logic [AW-1:0] b_ppc, g_ppc;
    logic          b_tk, g_tk;
    logic [IW-1:0] b_idx, g_idx;
    logic          b_ghr;
    logic [GW-1:0] g_ghr;

    always #5 clk = ~clk;

    branch_predictor_bht #(
        .ADDR_SIZE(AW), .ENTRIES(ENT), .CNT_W(CW), .INIT_CNT(INIT), .GHR_W(0)
    ) u_bim (
        .clk(clk), .rstn(rstn), .instr(instr), .pc(pc), .pcplus4(pcplus4),
        .fetch_en(fetch_en), .predicted_pc(b_ppc), .pred_taken(b_tk),
        .pred_idx(b_idx), .pred_ghr(b_ghr), .upd_valid(upd_valid),
        .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr[0])
    );

    branch_predictor_bht #(
        .ADDR_SIZE(AW), .ENTRIES(ENT), .CNT_W(CW), .INIT_CNT(INIT), .GHR_W(GW)
    ) u_gsh (
        .clk(clk), .rstn(rstn), .instr(instr), .pc(pc), .pcplus4(pcplus4),
        .fetch_en(fetch_en), .predicted_pc(g_ppc), .pred_taken(g_tk),
        .pred_idx(g_idx), .pred_ghr(g_ghr), .upd_valid(upd_valid),
        .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr)
    );

    // ------------------------------------------------------------------
    // Reference model: integer counters and an integer history value.
    // Both DUTs receive identical updates, so one table serves both.
    // ------------------------------------------------------------------
    int cnt [ENT];
    int ghr_m;
    int n_tests = 0;
    int n_fail  = 0;

    function automatic bit m_is_br(input logic [31:0] i);
        return i[6:0] == 7'h63;
    endfunction

    function automatic bit m_is_jal(input logic [31:0] i);
        return i[6:0] == 7'h6F;
    endfunction

    function automatic int m_bimm(input logic [31:0] i);
        int v;
        v = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048;
        if (i[31]) v = v - 4096;
        return v;
    endfunction

    function automatic int m_jimm(input logic [31:0] i);
        int v;
        v = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096;
        if (i[31]) v = v - (1 << 20);
        return v;
    endfunction

    function automatic int m_pc_idx(input logic [31:0] p);
        return int'((p / 4) % ENT);
    endfunction

    function automatic logic [31:0] m_ppc(input logic [31:0] p, input logic [31:0] i,
                                          input bit tk);
        if (m_is_jal(i)) return p + 32'(m_jimm(i));
        if (tk)          return p + 32'(m_bimm(i));
        return p + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) cnt[i] = INIT;
        ghr_m = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int bi, gi2;
        bit btk, gtk;
        bi  = m_pc_idx(pc);
        gi2 = bi ^ ghr_m;
        btk = m_is_br(instr) && (cnt[bi]  >= THR);
        gtk = m_is_br(instr) && (cnt[gi2] >= THR);
        chk({tag, "_bim_taken"}, 32'(b_tk),  32'(btk));
        chk({tag, "_bim_ppc"},   b_ppc,      m_ppc(pc, instr, btk));
        chk({tag, "_bim_idx"},   32'(b_idx), 32'(bi));
        chk({tag, "_bim_ghr"},   32'(b_ghr), 32'd0);
        chk({tag, "_gsh_taken"}, 32'(g_tk),  32'(gtk));
        chk({tag, "_gsh_ppc"},   g_ppc,      m_ppc(pc, instr, gtk));
        chk({tag, "_gsh_idx"},   32'(g_idx), 32'(gi2));
        chk({tag, "_gsh_ghr"},   32'(g_ghr), 32'(ghr_m));
    endtask

    // One rising edge: model state advances from the inputs held across it.
    task automatic tick();
        int gi2;
        bit gtk;
        gi2 = m_pc_idx(pc) ^ ghr_m;
        gtk = m_is_br(instr) && (cnt[gi2] >= THR);
        @(posedge clk);
        if (upd_valid) begin
            if (upd_taken) cnt[upd_idx] = (cnt[upd_idx] + 1 > CMAX) ? CMAX : cnt[upd_idx] + 1;
            else           cnt[upd_idx] = (cnt[upd_idx] - 1 < 0) ? 0 : cnt[upd_idx] - 1;
        end
        if (upd_valid && upd_mispredict)
            ghr_m = ((int'(upd_ghr) * 2) + int'(upd_taken)) % (1 << GW);
        else if (fetch_en && m_is_br(instr))
            ghr_m = ((ghr_m * 2) + int'(gtk)) % (1 << GW);
        @(negedge clk);
    endtask

    task automatic set_fetch(input logic [31:0] p, input logic [31:0] i, input logic fe);
        pc = p; pcplus4 = p + 32'd4; instr = i; fetch_en = fe;
    endtask

    task automatic set_upd(input logic v, input int idx, input logic tk, input logic mis,
                           input logic [GW-1:0] g);
        upd_valid = v; upd_idx = IW'(idx); upd_taken = tk; upd_mispredict = mis; upd_ghr = g;
    endtask

    initial begin
        // ---- 1: reset state -------------------------------------------
        model_reset();
        set_fetch(32'h100, BEQ, 1'b0);
        set_upd(0, 0, 0, 0, '0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_taken", 32'(b_tk), 32'd0);
        chk("rst_ppc", b_ppc, 32'h104);
        chk("rst_idx", 32'(b_idx), 32'd0);
        chk("rst_ghr", 32'(g_ghr), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // ---- 2: training and saturation on entry 0 --------------------
        set_upd(1, 0, 1, 0, '0);
        tick(); tick();
        set_upd(0, 0, 0, 0, '0);
        #1;
        chk("train_taken", 32'(b_tk), 32'd1);
        chk("train_ppc", b_ppc, 32'h110);
        check_all("train");
        set_upd(1, 0, 1, 0, '0);
        repeat (5) tick();
        set_upd(1, 0, 0, 0, '0);
        tick();  // a wrapped counter would now read 0 and predict not-taken
        set_upd(0, 0, 0, 0, '0);
        #1;
        chk("sat_hi", 32'(b_tk), 32'd1);
        set_upd(1, 0, 0, 0, '0);
        repeat (3) tick();  // four not-taken in total since saturation
        set_upd(0, 0, 0, 0, '0);
        #1;
        chk("dec_to_zero", 32'(b_tk), 32'd0);
        set_upd(1, 0, 0, 0, '0);
        tick();  // a wrapped counter would read 3 and predict taken
        set_upd(0, 0, 0, 0, '0);
        #1;
        chk("sat_lo", 32'(b_tk), 32'd0);
        check_all("sat");

        // ---- 3: JAL and non-branch ------------------------------------
        set_fetch(32'h200, JAL, 1'b1);
        #1;
        chk("jal_ppc", b_ppc, 32'h220);
        chk("jal_taken", 32'(b_tk), 32'd0);
        chk("jal_gsh_taken", 32'(g_tk), 32'd0);
        tick();
        #1;
        chk("jal_ghr_hold", 32'(g_ghr), 32'd0);
        set_fetch(32'h300, NOP, 1'b1);
        #1;
        chk("nop_ppc", b_ppc, 32'h304);
        chk("nop_gsh_ppc", g_ppc, 32'h304);
        tick();

        // ---- 4: gshare history build-up -------------------------------
        set_fetch(32'h104, BEQ, 1'b0);
        set_upd(1, 1, 1, 0, '0);
        tick(); tick();             // entry 1 -> 3
        set_upd(1, 0, 1, 0, '0);
        tick(); tick();             // entry 0 -> 2
        set_upd(0, 0, 0, 0, '0);
        fetch_en = 1'b1;
        #1;
        chk("ghr_f1_taken", 32'(g_tk), 32'd1);
        tick();
        #1;
        chk("ghr_f2_taken", 32'(g_tk), 32'd1);
        tick();
        #1;
        chk("ghr_f3_taken", 32'(g_tk), 32'd0);
        tick();
        #1;
        chk("ghr_0110", 32'(g_ghr), 32'h6);
        set_fetch(32'h100, BEQ, 1'b0);
        #1;
        chk("ghr_idx6", 32'(g_idx), 32'd6);
        check_all("ghr");

        // ---- 5: repair wins over speculative shift --------------------
        set_upd(1, 6, 1, 0, '0);
        tick();                     // entry 6 -> 2
        set_upd(1, 10, 0, 1, 4'b0001);
        set_fetch(32'h100, BEQ, 1'b1);
        #1;
        chk("rep_pred_taken", 32'(g_tk), 32'd1);
        tick();
        set_upd(0, 0, 0, 0, '0);
        fetch_en = 1'b0;
        #1;
        chk("rep_ghr", 32'(g_ghr), 32'h2);

        // ---- 6: read/write collision, no bypass -----------------------
        set_fetch(32'h100, BEQ, 1'b0);
        set_upd(1, 0, 0, 0, '0);    // entry 0: 2 -> 1
        #1;
        chk("coll_old", 32'(b_tk), 32'd1);
        tick();
        set_upd(0, 0, 0, 0, '0);
        #1;
        chk("coll_new", 32'(b_tk), 32'd0);
        check_all("coll");

        // ---- random traffic against the model -------------------------
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r = $urandom;
            case ($urandom_range(0, 3))
                0, 1: instr = {r[31:7], 7'h63};
                2:    instr = {r[31:7], 7'h6F};
                default: instr = r;
            endcase
            pc = $urandom & 32'hFFFF_FFFC;
            pcplus4 = pc + 32'd4;
            fetch_en = 1'($urandom_range(0, 1));
            set_upd(1'($urandom_range(0, 1)), int'($urandom_range(0, ENT - 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    GW'($urandom));
            #1;
            check_all("rnd");
            tick();
        end

        // ---- asynchronous reset mid-cycle ------------------------------
        set_fetch(32'h100, BEQ, 1'b0);
        set_upd(1, 0, 1, 0, '0);
        tick(); tick(); tick();     // entry 0 saturates high
        set_upd(1, 20, 1, 1, 4'b1010);
        tick();                     // ghr -> 0101
        set_upd(0, 0, 0, 0, '0);
        #1;
        chk("pre_rst_taken", 32'(b_tk), 32'd1);
        chk("pre_rst_ghr", 32'(g_ghr), 32'h5);
        #1 rstn = 1'b0;
        #1;
        model_reset();
        chk("arst_taken", 32'(b_tk), 32'd0);
        chk("arst_ppc", b_ppc, 32'h104);
        chk("arst_ghr", 32'(g_ghr), 32'd0);
        check_all("arst");
        #1 rstn = 1'b1;
        tick();
        #1;
        check_all("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
Parametrised dynamic branch predictor for the IF stage. It owns an internal pattern history table (PHT) of saturating counters and an optional speculative global history register (gshare mode). Each cycle it produces a next-PC prediction for the fetched instruction. Execute-stage resolution trains the table through an update port, and a mispredict report repairs the history register.

Parameters:
ADDR_SIZE, 32, PC/address width.
ENTRIES, 64, PHT entry count; power of 2, ≥4; IDX_W = log2(ENTRIES).
CNT_W, 2, counter width; 1..4; predict taken iff counter MSB = 1.
INIT_CNT, 1, reset value of every counter (weakly not-taken for CNT_W=2).
GHR_W, 0, global history bits; 0 = bimodal; otherwise 1..IDX_W.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  asynchronous active-low reset.
instr  in  32  fetched instruction.
pc  in  ADDR_SIZE  fetch PC.
pcplus4  in  ADDR_SIZE  pc+4.
fetch_en  in  1  IF advancing this cycle (not stalled, not flushed).
predicted_pc  out  ADDR_SIZE  next fetch PC.
pred_taken  out  1  prediction for current instr.
pred_idx  out  IDX_W  PHT index used; piped to EX.
pred_ghr  out  max(GHR_W,1)  GHR snapshot used; piped to EX; 0 when GHR_W=0.
upd_valid  in  1  a conditional branch resolved in EX this cycle.
upd_idx  in  IDX_W  pred_idx carried with that branch.
upd_taken  in  1  actual outcome.
upd_mispredict  in  1  outcome differed from pred_taken (qualified by upd_valid).
upd_ghr  in  max(GHR_W,1)  pred_ghr carried with that branch.

Behaviour:
- Decode: is_br = instr[6:0]==7'b1100011. is_jal = instr[6:0]==7'b1101111. B-imm and J-imm are sign-extended to ADDR_SIZE, with bit 0 = 0.
- Index: bimodal idx = pc[IDX_W+1:2]. Gshare idx = pc[IDX_W+1:2] XOR zero-extended ghr.
- Prediction is combinational in the same cycle. pred_taken = is_br & pht[idx][CNT_W-1].
- predicted_pc selection, in order:
  - is_jal → pc + J-imm (always taken).
  - pred_taken → pc + B-imm.
  - otherwise → pcplus4.
- pred_taken = 0 for JAL and for non-branches. pred_idx = idx and pred_ghr = ghr, always driven.
- PHT update at posedge when upd_valid:
  - upd_taken → pht[upd_idx] = min(cnt+1, 2^CNT_W-1).
  - else → pht[upd_idx] = max(cnt-1, 0).
  - Saturates; never wraps.
- Read/write collision (same index, same cycle): prediction sees the pre-update value; no bypass.
- GHR (GHR_W>0), updated at posedge:
  - Priority 1: upd_valid & upd_mispredict → ghr = {upd_ghr[GHR_W-2:0], upd_taken}. The repair wins over any simultaneous fetch shift.
  - Else fetch_en & is_br → ghr = {ghr[GHR_W-2:0], pred_taken}.
  - Else hold.
  - For GHR_W=1 the shift is just the new bit.
  - No GHR storage exists when GHR_W=0.
- Reset (rstn low, asynchronous):
  - Every PHT entry = INIT_CNT; ghr = 0.
  - Outputs stay combinational from reset state: for INIT_CNT=1, CNT_W=2 a branch predicts not-taken, predicted_pc = pcplus4.
  - Reset asserted mid-operation discards all training immediately, without waiting for a clock edge.
- Training and prediction ignore fetch_en, except for the GHR shift.
- No internal latency beyond one-cycle visibility of updates.

Test Plan:
1. Reset, CNT_W=2, INIT_CNT=1, bimodal; pc=0x100, instr=0x00000863 (beq x0,x0,+16) → pred_taken=0, predicted_pc=0x104, pred_idx=0.
2. Two upd_valid cycles (upd_idx=0, upd_taken=1), then same fetch → counter=3, pred_taken=1, predicted_pc=0x110. Five further taken updates → stays 3. Four not-taken updates → 0; a further one → stays 0.
3. instr=0x0200006F (jal x0,+32), pc=0x200 → predicted_pc=0x220, pred_taken=0, no GHR change. instr=0x00000013 (nop) → predicted_pc=pcplus4.
4. GHR_W=4: three fetch_en branch fetches predicted taken, taken, not-taken → ghr=4'b0110. pc=0x100 then indexes entry 6.
5. Same cycle: fetch_en with branch predicted taken, plus upd_valid, upd_mispredict=1, upd_ghr=4'b0001, upd_taken=0 → ghr=4'b0010 (repair wins).
6. Collision: upd_valid on idx 0 while fetching pc=0x100 → that cycle shows the old prediction, the next cycle shows the new one. Assert rstn low between edges → counters and ghr return to reset values immediately.
